// File: rtl/adc_capture_ctrl.sv
// Arm/trigger capture sequencer: after a trigger edge, forwards a programmed number of
// (optionally decimated) ADC samples as one AXI-Stream packet through a single holding register.
//
// state   | meaning
// IDLE    | waiting for arm
// ARMED   | config latched, waiting for trigger rising edge
// CAPTURE | selecting samples and loading the holding register
// DRAIN   | last sample loaded, waiting for its handshake
// DONE    | packet complete, held until next arm/abort
module adc_capture_ctrl #(
  parameter int INT_ADC_DATA_WIDTH  = 10,
  parameter int INT_AXIS_DATA_WIDTH = 32,
  parameter int INT_CNT_WIDTH       = 16
) (
  input  logic                           in_clk,
  input  logic                           in_rst,
  input  logic [INT_ADC_DATA_WIDTH-1:0]  in_adc_data,
  input  logic                           in_adc_valid,
  input  logic                           in_arm,
  input  logic                           in_abort,
  input  logic                           in_trig,
  input  logic [INT_CNT_WIDTH-1:0]       in_num_samples,
  input  logic [INT_CNT_WIDTH-1:0]       in_decim,
  output logic [INT_AXIS_DATA_WIDTH-1:0] out_tdata,
  output logic                           out_tvalid,
  input  logic                           in_tready,
  output logic                           out_tlast,
  output logic                           out_busy,
  output logic                           out_done,
  output logic                           out_overflow,
  output logic [INT_CNT_WIDTH-1:0]       out_sample_cnt
);

  if (INT_ADC_DATA_WIDTH > INT_AXIS_DATA_WIDTH) begin : g_width_check
    $error("adc_capture_ctrl: INT_ADC_DATA_WIDTH must not exceed INT_AXIS_DATA_WIDTH");
  end

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DRAIN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic                     trig_q;
  logic [INT_CNT_WIDTH-1:0] num_q;
  logic [INT_CNT_WIDTH-1:0] decim_q;
  logic [INT_CNT_WIDTH-1:0] decim_cnt;

  logic                     trig_edge;
  logic                     handshake;
  logic                     eligible;
  logic                     keep;
  logic                     load;
  logic                     last_load;
  logic                     arm_ok;
  logic [INT_CNT_WIDTH-1:0] cnt_next;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    trig_edge = in_trig & ~trig_q;
    handshake = out_tvalid & in_tready;
    eligible  = (state_q == CAPTURE) & in_adc_valid;
    keep      = eligible & (decim_cnt == '0);
    // A kept sample may enter the holding register only if it is empty or emptying this cycle.
    load      = keep & (~out_tvalid | in_tready);
    cnt_next  = out_sample_cnt + 1'b1;
    last_load = load & (cnt_next == num_q);
    arm_ok    = in_arm & (in_num_samples != '0) & ((state_q == IDLE) | (state_q == DONE));

    state_d = state_q;
    if (in_abort) begin
      state_d = IDLE;
    end else if (arm_ok) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        ARMED:   if (trig_edge) state_d = CAPTURE;
        CAPTURE: if (last_load) state_d = DRAIN;
        DRAIN:   if (handshake & out_tlast) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      trig_q         <= 1'b0;
      num_q          <= '0;
      decim_q        <= '0;
      decim_cnt      <= '0;
      out_tdata      <= '0;
      out_tvalid     <= 1'b0;
      out_tlast      <= 1'b0;
      out_overflow   <= 1'b0;
      out_sample_cnt <= '0;
    end else begin
      trig_q <= in_trig;
      if (in_abort) begin
        out_tvalid <= 1'b0;
        out_tlast  <= 1'b0;
      end else if (arm_ok) begin
        num_q          <= in_num_samples;
        decim_q        <= in_decim;
        out_sample_cnt <= '0;
        out_overflow   <= 1'b0;
        out_tvalid     <= 1'b0;
        out_tlast      <= 1'b0;
      end else begin
        if ((state_q == ARMED) && trig_edge) begin
          decim_cnt <= '0;
        end
        if (eligible) begin
          if (decim_cnt == '0) begin
            decim_cnt <= decim_q;
          end else begin
            decim_cnt <= decim_cnt - 1'b1;
          end
        end
        if (load) begin
          out_tdata      <= INT_AXIS_DATA_WIDTH'(in_adc_data);
          out_tvalid     <= 1'b1;
          out_tlast      <= last_load;
          out_sample_cnt <= cnt_next;
        end else if (handshake) begin
          out_tvalid <= 1'b0;
          out_tlast  <= 1'b0;
        end
        if (keep & ~load) begin
          out_overflow <= 1'b1;
        end
      end
    end
  end

  assign out_busy = (state_q == ARMED) | (state_q == CAPTURE) | (state_q == DRAIN);
  assign out_done = (state_q == DONE);

endmodule
